// File: rtl/pi_loop_sequencer_if.sv
// Bus bundle between the PI loop sequencer and its neighbours.
//   ADC side : adc_start (seq->adc), adc_data/adc_valid (adc->seq)
//   Pipeline : pipe_kp/ki/setpoint/actual/integral_input (seq->pipe),
//              pipe_integral_result/pipe_pi_result (pipe->seq)
//   DAC side : dac_data/dac_valid (seq->dac), dac_ready (dac->seq)
// master = sequencer view, slave = environment view.
interface pi_loop_sequencer_if #(
  parameter int unsigned INPUT_WIDTH  = 18,
  parameter int unsigned OUTPUT_WIDTH = 32
);
  logic                    adc_start;
  logic [INPUT_WIDTH-1:0]  adc_data;
  logic                    adc_valid;
  logic [OUTPUT_WIDTH-1:0] pipe_kp;
  logic [OUTPUT_WIDTH-1:0] pipe_ki;
  logic [INPUT_WIDTH-1:0]  pipe_setpoint;
  logic [INPUT_WIDTH-1:0]  pipe_actual;
  logic [OUTPUT_WIDTH-1:0] pipe_integral_input;
  logic [OUTPUT_WIDTH-1:0] pipe_integral_result;
  logic [OUTPUT_WIDTH-1:0] pipe_pi_result;
  logic [OUTPUT_WIDTH-1:0] dac_data;
  logic                    dac_valid;
  logic                    dac_ready;

  modport master (
    output adc_start, pipe_kp, pipe_ki, pipe_setpoint, pipe_actual, pipe_integral_input,
           dac_data, dac_valid,
    input  adc_data, adc_valid, pipe_integral_result, pipe_pi_result, dac_ready
  );

  modport slave (
    input  adc_start, pipe_kp, pipe_ki, pipe_setpoint, pipe_actual, pipe_integral_input,
           dac_data, dac_valid,
    output adc_data, adc_valid, pipe_integral_result, pipe_pi_result, dac_ready
  );
endinterface

// File: rtl/pi_loop_sequencer.sv
// Sequences one PI control iteration per loop-period tick: ADC request, pipeline
// load, latency wait, integral commit and DAC hand-off.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            run the loop while high
//   cfg_kp/ki         gains (signed), cfg_setpoint (signed), cfg_period (0 = free-run)
//   clear_integral    pulse: zero integral state, clear sticky flags
//   bus               ADC / pipeline / DAC bundle (master view)
//   busy              state != idle
//   overrun           sticky: period tick arrived while busy
//   adc_timeout       sticky: ADC did not answer in time
//   iter_count        completed iterations (wraps)
module pi_loop_sequencer #(
  parameter int unsigned INPUT_WIDTH  = 18,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned PIPE_LATENCY = 6,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned ADC_TIMEOUT  = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [OUTPUT_WIDTH-1:0] cfg_kp,
  input  logic [OUTPUT_WIDTH-1:0] cfg_ki,
  input  logic [INPUT_WIDTH-1:0]  cfg_setpoint,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic                    clear_integral,
  pi_loop_sequencer_if.master     bus,
  output logic                    busy,
  output logic                    overrun,
  output logic                    adc_timeout,
  output logic [31:0]             iter_count
);

  localparam int unsigned LatW = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned TmoW = $clog2(ADC_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StAdcReq, StAdcWait, StPipeWait, StDacWrite} state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                    enable_q, enable_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [OUTPUT_WIDTH-1:0] pipe_kp_q, pipe_kp_d, pipe_ki_q, pipe_ki_d;
  logic [INPUT_WIDTH-1:0]  pipe_sp_q, pipe_sp_d, pipe_actual_q, pipe_actual_d;
  logic [OUTPUT_WIDTH-1:0] integral_q, integral_d, dac_data_q, dac_data_d;
  logic                    pending_clear_q, pending_clear_d;
  logic                    dac_valid_q, dac_valid_d, adc_start_q, adc_start_d;
  logic                    overrun_q, overrun_d, adc_timeout_q, adc_timeout_d;
  logic [31:0]             iter_q, iter_d;

  logic free_run, tick, busy_w;

  assign free_run = (cfg_period == '0);
  // Enable rising counts as a tick, so the first iteration starts immediately.
  assign tick     = enable & (free_run | ~enable_q | (period_cnt_q == '0));
  assign busy_w   = (state_q != StIdle);

  always_comb begin
    state_d         = state_q;
    period_cnt_d    = period_cnt_q;
    enable_d        = enable;
    tmo_d           = tmo_q;
    lat_d           = lat_q;
    pipe_kp_d       = pipe_kp_q;
    pipe_ki_d       = pipe_ki_q;
    pipe_sp_d       = pipe_sp_q;
    pipe_actual_d   = pipe_actual_q;
    integral_d      = integral_q;
    dac_data_d      = dac_data_q;
    pending_clear_d = pending_clear_q;
    dac_valid_d     = dac_valid_q;
    adc_start_d     = 1'b0;
    overrun_d       = overrun_q;
    adc_timeout_d   = adc_timeout_q;
    iter_d          = iter_q;

    if (enable) begin
      if (tick) begin
        period_cnt_d = free_run ? '0 : cfg_period - PERIOD_WIDTH'(1);
      end else if (period_cnt_q != '0) begin
        period_cnt_d = period_cnt_q - PERIOD_WIDTH'(1);
      end
    end

    // Clear first so a coincident new event stays visible.
    if (clear_integral) begin
      overrun_d     = 1'b0;
      adc_timeout_d = 1'b0;
    end
    // In free-run every cycle ticks; only idle ticks matter there.
    if (tick && busy_w && !free_run) overrun_d = 1'b1;
    if (clear_integral && busy_w) pending_clear_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        // A clear left pending by an aborted iteration is applied here.
        if (clear_integral || pending_clear_q) begin
          integral_d      = '0;
          pending_clear_d = 1'b0;
        end
        if (tick) begin
          pipe_kp_d   = cfg_kp;
          pipe_ki_d   = cfg_ki;
          pipe_sp_d   = cfg_setpoint;
          adc_start_d = 1'b1;
          state_d     = StAdcReq;
        end
      end
      StAdcReq: begin
        tmo_d   = '0;
        state_d = StAdcWait;
      end
      StAdcWait: begin
        if (bus.adc_valid) begin
          pipe_actual_d = bus.adc_data;
          lat_d         = '0;
          state_d       = StPipeWait;
        end else if (tmo_q == TmoW'(ADC_TIMEOUT - 1)) begin
          adc_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StPipeWait: begin
        // lat_q == PIPE_LATENCY marks edge E0 + PIPE_LATENCY + 1.
        if (lat_q == LatW'(PIPE_LATENCY)) begin
          dac_data_d      = bus.pipe_pi_result;
          integral_d      = (clear_integral || pending_clear_q) ? '0 : bus.pipe_integral_result;
          pending_clear_d = 1'b0;
          dac_valid_d     = 1'b1;
          state_d         = StDacWrite;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StDacWrite: begin
        if (bus.dac_ready) begin
          dac_valid_d = 1'b0;
          iter_d      = iter_q + 32'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      period_cnt_q    <= '0;
      enable_q        <= 1'b0;
      tmo_q           <= '0;
      lat_q           <= '0;
      pipe_kp_q       <= '0;
      pipe_ki_q       <= '0;
      pipe_sp_q       <= '0;
      pipe_actual_q   <= '0;
      integral_q      <= '0;
      dac_data_q      <= '0;
      pending_clear_q <= 1'b0;
      dac_valid_q     <= 1'b0;
      adc_start_q     <= 1'b0;
      overrun_q       <= 1'b0;
      adc_timeout_q   <= 1'b0;
      iter_q          <= '0;
    end else begin
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      enable_q        <= enable_d;
      tmo_q           <= tmo_d;
      lat_q           <= lat_d;
      pipe_kp_q       <= pipe_kp_d;
      pipe_ki_q       <= pipe_ki_d;
      pipe_sp_q       <= pipe_sp_d;
      pipe_actual_q   <= pipe_actual_d;
      integral_q      <= integral_d;
      dac_data_q      <= dac_data_d;
      pending_clear_q <= pending_clear_d;
      dac_valid_q     <= dac_valid_d;
      adc_start_q     <= adc_start_d;
      overrun_q       <= overrun_d;
      adc_timeout_q   <= adc_timeout_d;
      iter_q          <= iter_d;
    end
  end

  assign bus.adc_start           = adc_start_q;
  assign bus.pipe_kp             = pipe_kp_q;
  assign bus.pipe_ki             = pipe_ki_q;
  assign bus.pipe_setpoint       = pipe_sp_q;
  assign bus.pipe_actual         = pipe_actual_q;
  assign bus.pipe_integral_input = integral_q;
  assign bus.dac_data            = dac_data_q;
  assign bus.dac_valid           = dac_valid_q;
  assign busy                    = busy_w;
  assign overrun                 = overrun_q;
  assign adc_timeout             = adc_timeout_q;
  assign iter_count              = iter_q;

endmodule

// File: doc/pi_loop_sequencer.md
Name: pi_loop_sequencer

Overview:
Sequences one closed-loop PI control iteration per loop-period tick.
- Starts an ADC conversion and loads the sample plus snapshotted gains and setpoint into the 6-stage PI pipeline.
- Waits out the pipeline latency, then commits the new integral state and hands the clamped result to the DAC writer over a valid/ready handshake.
- Sits between the ADC/DAC interface blocks and the PI pipeline; also owns the integral register and the period timer.

Parameters:
INPUT_WIDTH, 18, ADC sample / setpoint width
OUTPUT_WIDTH, 32, gain, integral and result width
PIPE_LATENCY, 6, edges from pipeline-input update to pi_result valid
PERIOD_WIDTH, 16, width of cfg_period
ADC_TIMEOUT, 1023, max cycles in ADC_WAIT before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run loop while high
cfg_kp  in  OUTPUT_WIDTH  proportional gain (signed)
cfg_ki  in  OUTPUT_WIDTH  integral gain (signed)
cfg_setpoint  in  INPUT_WIDTH  setpoint (signed)
cfg_period  in  PERIOD_WIDTH  loop period in clk cycles; 0 = free-run
clear_integral  in  1  pulse: zero integral state
adc_start  out  1  one-cycle conversion request
adc_data  in  INPUT_WIDTH  sample
adc_valid  in  1  sample valid (single cycle)
pipe_kp, pipe_ki  out  OUTPUT_WIDTH  to pipeline
pipe_setpoint, pipe_actual  out  INPUT_WIDTH  to pipeline
pipe_integral_input  out  OUTPUT_WIDTH  current integral register
pipe_integral_result  in  OUTPUT_WIDTH  updated integral from pipeline
pipe_pi_result  in  OUTPUT_WIDTH  clamped result from pipeline
dac_data  out  OUTPUT_WIDTH  result to DAC writer
dac_valid  out  1  dac_data valid
dac_ready  in  1  DAC writer accepts
busy  out  1  state != IDLE
overrun  out  1  sticky: period tick while busy
adc_timeout  out  1  sticky: ADC did not answer
iter_count  out  32  completed iterations, wraps

Behaviour:
- Reset: state IDLE; all outputs, integral register, pipe_* registers, period counter and iter_count = 0. Reset mid-cycle aborts immediately: no DAC write, no integral commit.
- Period timer:
  - Runs only while enable.
  - Reloads cfg_period-1 on tick or when enable rises.
  - Tick when counter = 0.
  - cfg_period = 0: tick every cycle, i.e. restart on return to IDLE.
- Tick while busy: set overrun, tick discarded. Overrun clears only on rst or clear_integral.
- States and transitions:
  - IDLE: on tick and enable, snapshot cfg_kp/cfg_ki/cfg_setpoint into pipe_kp/pipe_ki/pipe_setpoint, then go to ADC_REQ.
  - ADC_REQ: adc_start = 1 for exactly one cycle, then ADC_WAIT.
  - ADC_WAIT: on adc_valid, pipe_actual <= adc_data (load edge E0) and go to PIPE_WAIT. If ADC_TIMEOUT cycles elapse, set adc_timeout and return to IDLE with no commit.
  - PIPE_WAIT: hold all pipe_* stable. On edge E0 + PIPE_LATENCY + 1 (7 edges by default), sample pipe_pi_result into dac_data, commit integral <= pipe_integral_result, then go to DAC_WRITE.
  - DAC_WRITE: dac_valid = 1, dac_data held until the cycle dac_valid and dac_ready are both high. On that cycle: dac_valid drops the next cycle, iter_count += 1, go to IDLE. dac_valid never deasserts before acceptance.
- pipe_integral_input = integral register. It changes only at commit or clear, never during PIPE_WAIT.
- Snapshotted gains and setpoint are held until the next IDLE->ADC_REQ. cfg_* changes mid-iteration have no effect on that iteration.
- clear_integral:
  - In IDLE: integral <= 0 next edge.
  - In any other state: set pending_clear. At commit, integral <= 0 instead of the result; dac_data still takes pipe_pi_result. pending_clear then clears.
  - Also clears overrun and adc_timeout.
- Enable deasserted mid-iteration: the iteration completes, including the DAC handshake, then the block stays in IDLE.
- adc_valid outside ADC_WAIT is ignored.
- Simultaneous tick and DAC acceptance: acceptance wins; the tick counts as an overrun.

Test Plan:
- kp=2, ki=1, setpoint=10, ADC returns 15, integral 0 -> dac_data=15, integral=5; second iteration -> dac_data=20, integral=10; iter_count=2.
- kp=0x10000, ki=0, setpoint=0, ADC returns 100 -> dac_data=0x7FFFF (saturated); integral=100.
- cfg_period=50, ADC answers in 3 cycles, dac_ready=1 -> adc_start exactly every 50 cycles, overrun=0. Same with dac_ready held low 60 cycles -> overrun=1 and the next adc_start is delayed to the first tick after IDLE.
- ADC never asserts adc_valid -> adc_timeout=1 after 1023 cycles in ADC_WAIT, no dac_valid, integral unchanged.
- clear_integral pulsed during PIPE_WAIT (integral 40, error 5) -> dac_data reflects updated integral 45, committed integral=0. Change cfg_kp during ADC_WAIT -> pipe_kp unchanged until the next iteration.
- rst asserted in DAC_WRITE with dac_ready low -> next cycle dac_valid=0, busy=0, integral=0, iter_count=0.
